alu_shft_seq: RTL and testbench
===============================

# alu_shft_seq

Sequential, parametrised shifter/rotator for the Y80e ALU datapath. It takes a WIDTH-bit operand, a shift mode and a multi-bit shift count, and executes the shift over one or more clock cycles, STEP bits per cycle. It supports the full Z80 CB-group rotate/shift set, including rotate-through-carry. It returns the result, carry and S/Z/P flags with a start/busy/done handshake. It serves the extended-width and multi-bit shift instructions that the single-bit combinational shifter cannot cover.

## Interface
Parameters:
- WIDTH, 8, operand/result width (≥ 2)
- STEP, 1, bits shifted per cycle (1..WIDTH)
- CNT_W, clog2(WIDTH)+1, width of shift count

Ports:
- clkc  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; captured only in IDLE or DONE
- mode  in  3  000 RLC, 001 RRC, 010 RL, 011 RR, 100 SLA, 101 SRA, 110 SLL (shift in 1), 111 SRL
- count  in  CNT_W  number of single-bit shifts; 0 is legal
- carry_in  in  1  carry flag at start
- data_in  in  WIDTH  operand
- busy  out  1  high while shifting
- done  out  1  one-cycle completion pulse
- shft_out  out  WIDTH  working/result register
- shft_c  out  1  carry register
- sign_flag  out  1  shft_out[WIDTH-1]
- zero_flag  out  1  shft_out == 0
- par_flag  out  1  1 when shft_out has an even number of ones

## Operation
- States: IDLE, SHIFT, DONE.
- Reset (async): state IDLE. busy=0, done=0, shft_out=0, shft_c=0. Derived flags after reset: sign=0, zero=1, par=1.
- Capture edge: in IDLE or DONE with start=1, the block loads data_in into shft_out, carry_in into shft_c, and mode and count into internal registers, then enters SHIFT.
- SHIFT, each edge: apply n = min(STEP, remaining) single-bit shifts, decrement remaining by n. When remaining ≤ STEP, go to DONE after that edge. If remaining = 0 on entry, go to DONE with no change.
- Single-bit semantics (out = bit shifted out):
  - RLC/RRC: rotate WIDTH bits; c = out.
  - RL/RR: rotate WIDTH+1-bit ring including carry.
  - SLA: insert 0 at LSB. SLL: insert 1 at LSB.
  - SRA: replicate MSB. SRL: insert 0 at MSB.
  - For all shift modes, c = out.
- Count 0: result = data_in, shft_c = carry_in.
- count > WIDTH is legal and executed in full: rotates wrap, shifts saturate to the fill pattern.
- DONE: done=1 for exactly one cycle; then IDLE, unless start=1 recaptures.
- shft_out, shft_c and the flags hold after DONE until the next capture.
- start during SHIFT is ignored; no queuing.
- Flags are combinational from shft_out. They are meaningful only when done=1 or in IDLE after DONE.

## Timing
- Latency: done rises L = max(1, ceil(count/STEP)) edges after the capture edge.
- busy=1 for the L cycles in SHIFT; busy and done are never both 1.
- Back-to-back: start held high during the DONE cycle captures on that edge. Throughput is one op per L+1 cycles.
- Intermediate shft_out values are visible during SHIFT and are not guaranteed stable.
- Reset mid-SHIFT aborts immediately. No done pulse is generated; all outputs take their reset values.

## Structure
- Shared define file (the one holding AOP_* codes): mode codes SHM_RLC..SHM_SRL and state encodings ST_IDLE/ST_SHIFT/ST_DONE.
- Sub-module alu_shft_step: combinational single-bit shift of {c, data} by mode, parametrised by WIDTH. Instantiated STEP times in a chain. A per-stage enable implements the partial final step.
- Top level holds the FSM, remaining counter, operand/carry registers and flag logic.

## Test plan
- WIDTH=8, STEP=1, RLC, 0x81, count 1, carry_in 0 -> shft_out 0x03, shft_c 1, done 1 edge after capture, busy 1 cycle.
- RL, 0x80, carry_in 0, count 2 -> 0x01, shft_c 0, L=2. RR, 0x01, carry_in 1, count 9 -> 0x01, shft_c 1 (full 9-bit ring).
- WIDTH=8, STEP=2, SRA, 0x80, count 3 -> 0xF0, shft_c 0, sign 1, zero 0, par 1, L=2.
- Count 0, data 0x00, carry_in 1 -> 0x00, shft_c 1, zero 1, par 1, L=1. start pulsed during SHIFT is ignored; back-to-back start in DONE is accepted.
- WIDTH=16, STEP=4, SRL, 0xFFFF, count 16 -> 0x0000, shft_c 1, L=4. SLL, 0x0000, count 3 -> 0x0007.
- Reset asserted mid-SHIFT (count 5) -> busy/done/shft_out/shft_c go to 0 without a clock edge, no done pulse; the next start runs normally.

Source files
------------

// File: rtl/alu_shft_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_shft_seq_pkg
// Shared definitions for the sequential shifter/rotator:
//   - SHM_* : 3-bit shift/rotate mode codes (Z80 CB-group order)
//   - shft_state_t : FSM state encoding (ST_IDLE / ST_SHIFT / ST_DONE)
// ---------------------------------------------------------------------------
package alu_shft_seq_pkg;

    localparam logic [2:0] SHM_RLC = 3'b000;  // rotate left, c = old MSB
    localparam logic [2:0] SHM_RRC = 3'b001;  // rotate right, c = old LSB
    localparam logic [2:0] SHM_RL  = 3'b010;  // rotate left through carry
    localparam logic [2:0] SHM_RR  = 3'b011;  // rotate right through carry
    localparam logic [2:0] SHM_SLA = 3'b100;  // shift left, 0 in
    localparam logic [2:0] SHM_SRA = 3'b101;  // shift right, MSB replicated
    localparam logic [2:0] SHM_SLL = 3'b110;  // shift left, 1 in
    localparam logic [2:0] SHM_SRL = 3'b111;  // shift right, 0 in

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } shft_state_t;

endpackage

// File: rtl/alu_shft_step.sv
// ---------------------------------------------------------------------------
// alu_shft_step
// Combinational single-bit shift/rotate of {c, data} selected by mode.
// When en is low the stage passes data and carry through unchanged, which
// lets a chain of these stages execute a partial final step.
// Ports:
//   en        stage enable
//   mode      SHM_* mode code
//   data_in   operand, c_in carry
//   data_out  shifted operand, c_out carry (bit shifted out)
// ---------------------------------------------------------------------------
module alu_shft_step
    import alu_shft_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] data_in,
    input  logic             c_in,
    output logic [WIDTH-1:0] data_out,
    output logic             c_out
);

    always_comb begin
        data_out = data_in;
        c_out    = c_in;
        if (en) begin
            case (mode)
                SHM_RLC: begin
                    data_out = {data_in[WIDTH-2:0], data_in[WIDTH-1]};
                    c_out    = data_in[WIDTH-1];
                end
                SHM_RRC: begin
                    data_out = {data_in[0], data_in[WIDTH-1:1]};
                    c_out    = data_in[0];
                end
                SHM_RL: begin
                    data_out = {data_in[WIDTH-2:0], c_in};
                    c_out    = data_in[WIDTH-1];
                end
                SHM_RR: begin
                    data_out = {c_in, data_in[WIDTH-1:1]};
                    c_out    = data_in[0];
                end
                SHM_SLA: begin
                    data_out = {data_in[WIDTH-2:0], 1'b0};
                    c_out    = data_in[WIDTH-1];
                end
                SHM_SRA: begin
                    data_out = {data_in[WIDTH-1], data_in[WIDTH-1:1]};
                    c_out    = data_in[0];
                end
                SHM_SLL: begin
                    data_out = {data_in[WIDTH-2:0], 1'b1};
                    c_out    = data_in[WIDTH-1];
                end
                default: begin  // SHM_SRL
                    data_out = {1'b0, data_in[WIDTH-1:1]};
                    c_out    = data_in[0];
                end
            endcase
        end
    end

endmodule

// File: rtl/alu_shft_seq.sv
// ---------------------------------------------------------------------------
// alu_shft_seq
// Sequential shifter/rotator: executes `count` single-bit shifts of the
// operand, STEP bits per clock, with a start/busy/done handshake.
//
// Handshake: start is sampled only in IDLE or DONE; the sampling edge loads
// the operand and enters SHIFT. busy is high for every SHIFT cycle, done is
// high for exactly the single DONE cycle, and the two are never high
// together. Holding start during DONE recaptures on that same edge; start
// during SHIFT is ignored.
//
// Ports:
//   clkc, reset          clock (rising edge), async active-high reset
//   start, mode, count   request, SHM_* mode, number of single-bit shifts
//   carry_in, data_in    initial carry and operand
//   busy, done           status (see handshake above)
//   shft_out, shft_c     working/result register and carry register
//   sign/zero/par_flag   combinational flags of shft_out (par: even ones)
//   state_dbg            current FSM state for observation
// ---------------------------------------------------------------------------
module alu_shft_seq
    import alu_shft_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clkc,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] shft_out,
    output logic             shft_c,
    output logic             sign_flag,
    output logic             zero_flag,
    output logic             par_flag,
    output logic [1:0]       state_dbg
);

    localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

    shft_state_t      state, state_nxt;
    logic [2:0]       mode_q;
    logic [CNT_W-1:0] rem_q;
    logic             capture;
    logic             last_step;

    // Stage chain: element 0 is the register, element STEP the next value.
    logic [WIDTH-1:0] chain_d [STEP+1];
    logic             chain_c [STEP+1];

    assign chain_d[0] = shft_out;
    assign chain_c[0] = shft_c;

    // Stage i runs only while more than i shifts remain, so the last cycle
    // of a count that is not a multiple of STEP applies just the remainder.
    for (genvar i = 0; i < STEP; i++) begin : g_step
        alu_shft_step #(.WIDTH(WIDTH)) u_step (
            .en       (rem_q > CNT_W'(i)),
            .mode     (mode_q),
            .data_in  (chain_d[i]),
            .c_in     (chain_c[i]),
            .data_out (chain_d[i+1]),
            .c_out    (chain_c[i+1])
        );
    end

    assign capture   = start && (state == ST_IDLE || state == ST_DONE);
    assign last_step = (rem_q <= STEP_C);

    // FSM state register
    always_ff @(posedge clkc or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // FSM next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SHIFT;
            ST_SHIFT: if (last_step) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = start ? ST_SHIFT : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Operand, carry, mode and remaining-count registers
    always_ff @(posedge clkc or posedge reset) begin
        if (reset) begin
            shft_out <= '0;
            shft_c   <= 1'b0;
            mode_q   <= SHM_RLC;
            rem_q    <= '0;
        end else if (capture) begin
            shft_out <= data_in;
            shft_c   <= carry_in;
            mode_q   <= mode;
            rem_q    <= count;
        end else if (state == ST_SHIFT) begin
            // With rem_q == 0 every stage is disabled: value passes unchanged.
            shft_out <= chain_d[STEP];
            shft_c   <= chain_c[STEP];
            rem_q    <= last_step ? '0 : rem_q - STEP_C;
        end
    end

    assign busy      = (state == ST_SHIFT);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    assign sign_flag = shft_out[WIDTH-1];
    assign zero_flag = (shft_out == '0);
    assign par_flag  = ~^shft_out;

endmodule

// File: tb/tb_alu_shft_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_shft_seq
// Three instances share the request buses and have private start lines:
//   a: WIDTH=8  STEP=1    b: WIDTH=8  STEP=2    c: WIDTH=16 STEP=4
// Each request pushes a hand-computed {carry, data} and latency into that
// instance's queues; a per-instance monitor pops on done and compares data,
// carry, flags and the number of busy cycles.
// ---------------------------------------------------------------------------
module tb_alu_shft_seq;
    import alu_shft_seq_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  mode = 3'b000;
    logic [4:0]  cnt = 5'd0;
    logic        cin = 1'b0;
    logic [15:0] din = 16'h0;
    logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

    logic        busy_a, done_a, c_a, s_a, z_a, p_a;
    logic        busy_b, done_b, c_b, s_b, z_b, p_b;
    logic        busy_c, done_c, c_c, s_c, z_c, p_c;
    logic [7:0]  out_a, out_b;
    logic [15:0] out_c;
    logic [1:0]  st_a, st_b, st_c;

    logic [16:0] exp_qa[$], exp_qb[$], exp_qc[$];
    int          lat_qa[$], lat_qb[$], lat_qc[$];
    int          bc_a = 0, bc_b = 0, bc_c = 0;
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    alu_shft_seq #(.WIDTH(8), .STEP(1)) dut_a (
        .clkc(clk), .reset(reset), .start(start_a), .mode(mode), .count(cnt[3:0]),
        .carry_in(cin), .data_in(din[7:0]), .busy(busy_a), .done(done_a),
        .shft_out(out_a), .shft_c(c_a), .sign_flag(s_a), .zero_flag(z_a),
        .par_flag(p_a), .state_dbg(st_a)
    );
    alu_shft_seq #(.WIDTH(8), .STEP(2)) dut_b (
        .clkc(clk), .reset(reset), .start(start_b), .mode(mode), .count(cnt[3:0]),
        .carry_in(cin), .data_in(din[7:0]), .busy(busy_b), .done(done_b),
        .shft_out(out_b), .shft_c(c_b), .sign_flag(s_b), .zero_flag(z_b),
        .par_flag(p_b), .state_dbg(st_b)
    );
    alu_shft_seq #(.WIDTH(16), .STEP(4)) dut_c (
        .clkc(clk), .reset(reset), .start(start_c), .mode(mode), .count(cnt),
        .carry_in(cin), .data_in(din), .busy(busy_c), .done(done_c),
        .shft_out(out_c), .shft_c(c_c), .sign_flag(s_c), .zero_flag(z_c),
        .par_flag(p_c), .state_dbg(st_c)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Compare one completed operation against its expected entry.
    task automatic compare_op(input string nm, input int w, input logic [16:0] e, input int l,
                              input logic [15:0] got_d, input logic got_c, input logic got_s,
                              input logic got_z, input logic got_p, input logic got_busy,
                              input int got_l);
        logic [15:0] mask;
        logic [15:0] ed;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        ed   = e[15:0] & mask;
        check({nm, "_data"}, 32'(got_d), 32'(ed));
        check({nm, "_carry"}, 32'(got_c), 32'(e[16]));
        check({nm, "_sign"}, 32'(got_s), 32'(ed[w-1]));
        check({nm, "_zero"}, 32'(got_z), 32'(ed == 16'h0));
        check({nm, "_par"}, 32'(got_p), 32'(($countones(ed) % 2) == 0));
        check({nm, "_busy_at_done"}, 32'(got_busy), 32'd0);
        check({nm, "_latency"}, 32'(got_l), 32'(l));
    endtask

    task automatic unexpected(input string nm);
        total++;
        bad++;
        $display("FAIL %s_unexpected_done: got=done expected=no_done", nm);
    endtask

    // Monitors
    always @(negedge clk) if (!reset) begin
        if (done_a) begin
            if (exp_qa.size() == 0) unexpected("a");
            else compare_op("a", 8, exp_qa.pop_front(), lat_qa.pop_front(), {8'h0, out_a},
                            c_a, s_a, z_a, p_a, busy_a, bc_a);
            bc_a = 0;
        end
        if (busy_a) bc_a++;
    end

    always @(negedge clk) if (!reset) begin
        if (done_b) begin
            if (exp_qb.size() == 0) unexpected("b");
            else compare_op("b", 8, exp_qb.pop_front(), lat_qb.pop_front(), {8'h0, out_b},
                            c_b, s_b, z_b, p_b, busy_b, bc_b);
            bc_b = 0;
        end
        if (busy_b) bc_b++;
    end

    always @(negedge clk) if (!reset) begin
        if (done_c) begin
            if (exp_qc.size() == 0) unexpected("c");
            else compare_op("c", 16, exp_qc.pop_front(), lat_qc.pop_front(), out_c,
                            c_c, s_c, z_c, p_c, busy_c, bc_c);
            bc_c = 0;
        end
        if (busy_c) bc_c++;
    end

    // Driver: present a request, push its expectation, hold start for one edge.
    task automatic issue(input int which, input logic [2:0] m, input logic [4:0] n,
                         input logic ci, input logic [15:0] d,
                         input logic [15:0] ed, input logic ec, input int el);
        mode = m;
        cnt  = n;
        cin  = ci;
        din  = d;
        case (which)
            0: begin exp_qa.push_back({ec, ed}); lat_qa.push_back(el); start_a = 1'b1; end
            1: begin exp_qb.push_back({ec, ed}); lat_qb.push_back(el); start_b = 1'b1; end
            default: begin exp_qc.push_back({ec, ed}); lat_qc.push_back(el); start_c = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
    endtask

    function automatic logic done_of(input int which);
        case (which)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    // Returns at the falling edge where done is visible.
    task automatic wait_done(input int which);
        int k = 0;
        while (!done_of(which) && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done_of(which)) begin
            total++;
            bad++;
            $display("FAIL wait_done_%0d: got=timeout expected=done", which);
        end
    endtask

    task automatic run(input int which, input logic [2:0] m, input logic [4:0] n,
                       input logic ci, input logic [15:0] d,
                       input logic [15:0] ed, input logic ec, input int el);
        issue(which, m, n, ci, d, ed, ec, el);
        wait_done(which);
        @(negedge clk);
    endtask

    task automatic check_reset(input string nm, input logic b, input logic dn,
                               input logic [15:0] o, input logic c,
                               input logic s, input logic z, input logic p);
        check({nm, "_rst_busy"}, 32'(b), 32'd0);
        check({nm, "_rst_done"}, 32'(dn), 32'd0);
        check({nm, "_rst_out"}, 32'(o), 32'd0);
        check({nm, "_rst_carry"}, 32'(c), 32'd0);
        check({nm, "_rst_sign"}, 32'(s), 32'd0);
        check({nm, "_rst_zero"}, 32'(z), 32'd1);
        check({nm, "_rst_par"}, 32'(p), 32'd1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_reset("a", busy_a, done_a, {8'h0, out_a}, c_a, s_a, z_a, p_a);
        check_reset("b", busy_b, done_b, {8'h0, out_b}, c_b, s_b, z_b, p_b);
        check_reset("c", busy_c, done_c, out_c, c_c, s_c, z_c, p_c);
        check("a_rst_state", 32'(st_a), 32'(ST_IDLE));
        reset = 1'b0;
        @(negedge clk);

        // Instance a: WIDTH=8, STEP=1
        run(0, SHM_RLC, 5'd1, 1'b0, 16'h0081, 16'h0003, 1'b1, 1);
        run(0, SHM_RL,  5'd2, 1'b0, 16'h0080, 16'h0001, 1'b0, 2);
        run(0, SHM_RR,  5'd9, 1'b1, 16'h0001, 16'h0001, 1'b1, 9);
        run(0, SHM_SLA, 5'd1, 1'b0, 16'h0081, 16'h0002, 1'b1, 1);

        // Reset mid-SHIFT: outputs clear without a clock edge, no done pulse.
        issue(0, SHM_RLC, 5'd5, 1'b0, 16'h0081, 16'h0, 1'b0, 5);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("a_midrst_busy", 32'(busy_a), 32'd0);
        check("a_midrst_done", 32'(done_a), 32'd0);
        check("a_midrst_out", 32'(out_a), 32'd0);
        check("a_midrst_carry", 32'(c_a), 32'd0);
        exp_qa.delete();
        lat_qa.delete();
        @(negedge clk);
        reset = 1'b0;
        bc_a = 0;
        @(negedge clk);
        run(0, SHM_RRC, 5'd1, 1'b0, 16'h0001, 16'h0080, 1'b1, 1);

        // Instance b: WIDTH=8, STEP=2
        run(1, SHM_SRA, 5'd3,  1'b0, 16'h0080, 16'h00F0, 1'b0, 2);
        run(1, SHM_RLC, 5'd0,  1'b1, 16'h0000, 16'h0000, 1'b1, 1);
        run(1, SHM_RLC, 5'd8,  1'b0, 16'h0012, 16'h0012, 1'b0, 4);
        run(1, SHM_SLA, 5'd10, 1'b0, 16'h00FF, 16'h0000, 1'b0, 5);

        // start pulsed during SHIFT is ignored
        issue(1, SHM_SRL, 5'd5, 1'b0, 16'h00AB, 16'h0005, 1'b0, 3);
        @(negedge clk);
        mode = SHM_RLC;
        cnt  = 5'd1;
        din  = 16'h00FF;
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
        wait_done(1);
        @(negedge clk);

        // back-to-back: start held in the DONE cycle recaptures
        issue(1, SHM_RR, 5'd1, 1'b0, 16'h0001, 16'h0000, 1'b1, 1);
        wait_done(1);
        issue(1, SHM_SLL, 5'd2, 1'b0, 16'h0000, 16'h0003, 1'b0, 1);
        wait_done(1);
        @(negedge clk);

        // Instance c: WIDTH=16, STEP=4
        run(2, SHM_SRL, 5'd16, 1'b0, 16'hFFFF, 16'h0000, 1'b1, 4);
        run(2, SHM_SLL, 5'd3,  1'b0, 16'h0000, 16'h0007, 1'b0, 1);
        run(2, SHM_RL,  5'd17, 1'b1, 16'h8000, 16'h8000, 1'b1, 5);
        run(2, SHM_RRC, 5'd5,  1'b0, 16'h0001, 16'h0800, 1'b0, 2);

        repeat (4) @(negedge clk);
        check("a_queue_left", 32'(exp_qa.size()), 32'd0);
        check("b_queue_left", 32'(exp_qb.size()), 32'd0);
        check("c_queue_left", 32'(exp_qc.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
